pipe_scheduler: RTL

Sequencer for the pipe-gap datapath. It owns the ring of `N_PIPE` pipe slots, each holding a position, a max bound and a min bound. It scrolls the slots at a divided rate and respawns the leading slot with a pseudo-random gap. It also counts pipes the bird has cleared. The controller drives it with `start`/`halt`; the view and the collision logic consume the packed `pipes` bus.

---
 rtl/pipe_scheduler_if.sv | 14 +
 rtl/pipe_scheduler.sv | 121 ++++++++++++
 2 files changed

// File: rtl/pipe_scheduler_if.sv
// pipe_scheduler_if: control inputs and packed pipe-slot outputs of the pipe scheduler
interface pipe_scheduler_if #(
    parameter int N_PIPE = 3
);
    logic                  start;
    logic                  halt;
    logic [7:0]            n_row;
    logic [24*N_PIPE-1:0]  pipes;
    logic                  valid;
    logic                  passed;
    logic [15:0]           score;
    modport master (output start, halt, n_row, input pipes, valid, passed, score);
    modport slave (input start, halt, n_row, output pipes, valid, passed, score);
endinterface

// File: rtl/pipe_scheduler.sv
// pipe_scheduler: pipe slot ring sequencer with LFSR gap respawn; scoring enabled by PIPE_SCHED_SCORE_EN
module pipe_scheduler #(
    parameter int N_PIPE     = 3,
    parameter int GAP_LEN    = 8,
    parameter int PIPE_GAP   = 50,
    parameter int SCROLL_DIV = 3,
    parameter int PASS_COL   = 4,
    parameter int MAX_TRIES  = 16
) (
    input logic clk,
    input logic rst,
    pipe_scheduler_if.slave bus
);
`ifdef PIPE_SCHED_SCORE_EN
    localparam bit SCORE_EN = 1'b1;
`else
    localparam bit SCORE_EN = 1'b0;
`endif
    localparam int IW = $clog2(N_PIPE + 1);
    localparam int CW = $clog2(SCROLL_DIV + 1);
    localparam int TW = $clog2(MAX_TRIES + 1);
    typedef enum logic [2:0] {IDLE, SEED, RUN, SPAWN, HALT} state_t;
    state_t state, state_n;
    logic [15:0] lfsr;
    logic [7:0] pos [N_PIPE];
    logic [7:0] mx [N_PIPE];
    logic [7:0] mn [N_PIPE];
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tries;
    logic valid, passed;
    logic [15:0] score;
    logic fits, accept, tick, last_seed, restart, draw, scroll, pass;
    logic [7:0] new_min;
    // candidate acceptance, scroll tick and next state
    always_comb begin
        fits = bus.n_row > 8'(GAP_LEN) && lfsr[7:0] < bus.n_row - 8'(GAP_LEN);
        accept = fits || bus.n_row <= 8'(GAP_LEN) || tries == TW'(MAX_TRIES - 1);
        new_min = fits ? lfsr[7:0] : 8'd0;
        tick = cnt == CW'(SCROLL_DIV - 1);
        last_seed = idx == IW'(N_PIPE - 1);
        restart = (state == IDLE || state == HALT) && bus.start;
        draw = (state == SEED || state == SPAWN) && !bus.halt;
        scroll = state == RUN && !bus.halt;
        pass = scroll && tick && pos[0] == 8'(PASS_COL);
        state_n = state;
        case (state)
            IDLE, HALT: state_n = bus.start ? SEED : state;
            SEED:       state_n = bus.halt ? HALT : (accept && last_seed) ? RUN : SEED;
            RUN:        state_n = bus.halt ? HALT : (tick && pos[0] == 8'd0) ? SPAWN : RUN;
            SPAWN:      state_n = bus.halt ? HALT : accept ? RUN : SPAWN;
            default:    state_n = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    // slot ring, LFSR and scroll/try/seed counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 16'hACE1;
            idx <= '0;
            cnt <= '0;
            tries <= '0;
            valid <= 1'b0;
            for (int i = 0; i < N_PIPE; i++) begin
                pos[i] <= 8'd0;
                mx[i] <= 8'd0;
                mn[i] <= 8'd0;
            end
        end else if (restart) begin
            idx <= '0;
            tries <= '0;
            valid <= 1'b0;
        end else if (draw) begin
            lfsr <= {^(lfsr & 16'h002D), lfsr[15:1]};
            tries <= accept ? '0 : tries + TW'(1);
            if (accept && state == SEED) begin
                pos[idx] <= 8'(PIPE_GAP * (int'(idx) + 1));
                mn[idx] <= new_min;
                mx[idx] <= new_min + 8'(GAP_LEN);
                idx <= idx + IW'(1);
                if (last_seed) begin
                    cnt <= '0;
                    valid <= 1'b1;
                end
            end else if (accept) begin
                for (int i = 0; i < N_PIPE - 1; i++) begin
                    pos[i] <= pos[i+1];
                    mx[i] <= mx[i+1];
                    mn[i] <= mn[i+1];
                end
                pos[N_PIPE-1] <= pos[N_PIPE-1] + 8'(PIPE_GAP);
                mn[N_PIPE-1] <= new_min;
                mx[N_PIPE-1] <= new_min + 8'(GAP_LEN);
            end
        end else if (scroll) begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick && pos[0] != 8'd0)
                for (int i = 0; i < N_PIPE; i++) pos[i] <= pos[i] - 8'd1;
        end
    end
    // cleared-pipe counter and pass pulse; constant zero when scoring is disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score <= 16'd0;
            passed <= 1'b0;
        end else begin
            passed <= SCORE_EN && pass;
            score <= restart ? 16'd0 : (SCORE_EN && pass) ? score + 16'd1 : score;
        end
    end
    assign bus.valid = valid;
    assign bus.passed = passed;
    assign bus.score = score;
    for (genvar i = 0; i < N_PIPE; i++) begin : g_pack
        assign bus.pipes[24*i +: 24] = {pos[i], mx[i], mn[i]};
    end
endmodule
